pwm_channel_scheduler: RTL and testbench

PWM_CHANNEL_SCHEDULER -- requirements
Module: pwm_channel_scheduler

---
 rtl/pwm_sched_pkg.sv | 16 +
 rtl/pwm_rr_pick.sv | 20 ++
 rtl/pwm_channel_scheduler.sv | 141 ++++++++++++++
 tb/tb_pwm_channel_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_sched_pkg.sv
// pwm_sched_pkg: shared status codes, decoder guard patterns, pulse limits and FSM states
package pwm_sched_pkg;
   localparam int          CH_W             = 4;
   localparam logic [15:0] GUARD_ERROR_LOW  = 16'hC000;
   localparam logic [15:0] GUARD_ERROR_HIGH = 16'h8000;
   localparam logic [15:0] ON_MIN           = 16'd800;
   localparam logic [15:0] ON_MAX           = 16'd2600;
   typedef enum logic [1:0] {ST_OK = 2'd0, ST_RANGE = 2'd1, ST_LOST = 2'd2, ST_HIGH = 2'd3} status_t;
   typedef enum logic {S_IDLE, S_PRESENT} state_t;
   // The two top bits carry the decoder's error flags and take precedence over the pulse width.
   function automatic status_t classify(input logic [15:0] v);
      return ((v & GUARD_ERROR_LOW) == GUARD_ERROR_LOW)  ? ST_LOST :
             ((v & GUARD_ERROR_LOW) == GUARD_ERROR_HIGH) ? ST_HIGH :
             (v >= ON_MIN && v <= ON_MAX)                ? ST_OK   : ST_RANGE;
   endfunction
endpackage

// File: rtl/pwm_rr_pick.sv
// pwm_rr_pick: round-robin grant, first pending channel at or after the pointer
module pwm_rr_pick
   import pwm_sched_pkg::*;
#(
   parameter int NUM_CH = 8
) (
   input  logic [NUM_CH-1:0] pend_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic [CH_W-1:0]   grant_o,
   output logic              any_o
);
   // Scan from the farthest offset down so the nearest pending channel wins.
   always_comb begin
      grant_o = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pend_i[(int'(ptr_i) + i) % NUM_CH]) grant_o = CH_W'((int'(ptr_i) + i) % NUM_CH);
      end
   end
   assign any_o = |pend_i;
endmodule

// File: rtl/pwm_channel_scheduler.sv
// pwm_channel_scheduler: captures PWM decoder samples, streams them round-robin, tracks staleness
// Define PWM_SCHED_LASTGOOD_EN so the register file only keeps OK samples.
module pwm_channel_scheduler
   import pwm_sched_pkg::*;
#(
   parameter int NUM_CH     = 8,
   parameter int clockFreq  = 50000000,
   parameter int TIMEOUT_MS = 100
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [NUM_CH-1:0]    i_pwm_ready,
   input  logic [16*NUM_CH-1:0] i_pwm_value,
   output logic                 o_upd_valid,
   input  logic                 i_upd_ready,
   output logic [CH_W-1:0]      o_upd_ch,
   output logic [15:0]          o_upd_value,
   output logic [1:0]           o_upd_status,
   input  logic [CH_W-1:0]      i_rd_ch,
   output logic [15:0]          o_rd_value,
   output logic [NUM_CH-1:0]    o_ch_valid,
   output logic                 o_failsafe,
   output logic [NUM_CH-1:0]    o_overrun,
   input  logic                 i_clr_overrun
);
   localparam int SW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PRESC_MAX = clockFreq / 1000000 - 1;

   state_t            state_q, state_d;
   logic [NUM_CH-1:0] pend_q, pend_d, clr;
   logic [NUM_CH-1:0] valid_q, valid_d, ovr_q, ovr_d;
   logic [15:0]       shadow_q [NUM_CH];
   logic [15:0]       shadow_d [NUM_CH];
   logic [15:0]       regs_q   [NUM_CH];
   logic [15:0]       regs_d   [NUM_CH];
   logic [9:0]        age_q    [NUM_CH];
   logic [9:0]        age_d    [NUM_CH];
   logic [CH_W-1:0]   rr_q, rr_d, upd_ch_q, upd_ch_d, grant;
   logic [15:0]       upd_val_q, upd_val_d, rd_q, rd_d;
   status_t           upd_st_q, upd_st_d, cap_st;
   logic [31:0]       presc_q, presc_d;
   logic [9:0]        ms_cnt_q, ms_cnt_d;
   logic              any, us_tick, ms_tick, cap_ok;

   pwm_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
      .pend_i (pend_q),
      .ptr_i  (rr_q),
      .grant_o(grant),
      .any_o  (any)
   );

   assign us_tick  = presc_q == 32'(PRESC_MAX);
   assign ms_tick  = us_tick && ms_cnt_q == 10'd999;
   assign presc_d  = us_tick ? '0 : presc_q + 32'd1;
   assign ms_cnt_d = ms_tick ? '0 : us_tick ? ms_cnt_q + 10'd1 : ms_cnt_q;

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      upd_ch_d  = upd_ch_q;
      upd_val_d = upd_val_q;
      upd_st_d  = upd_st_q;
      clr       = '0;
      cap_st    = ST_OK;
      cap_ok    = 1'b0;
      if (state_q == S_IDLE && any) begin
         state_d                = S_PRESENT;
         upd_ch_d               = grant;
         upd_val_d              = shadow_q[grant[SW-1:0]];
         upd_st_d               = classify(shadow_q[grant[SW-1:0]]);
         clr[grant[SW-1:0]]     = 1'b1;
      end else if (state_q == S_PRESENT && i_upd_ready) begin
         state_d = S_IDLE;
         rr_d    = (upd_ch_q == CH_W'(NUM_CH - 1)) ? '0 : upd_ch_q + 1'b1;
      end
      // A capture on the same edge as the grant keeps the channel pending: the grant takes the old sample.
      for (int k = 0; k < NUM_CH; k++) begin
         cap_st      = classify(i_pwm_value[16*k +: 16]);
         cap_ok      = i_pwm_ready[k] && cap_st == ST_OK;
         pend_d[k]   = (pend_q[k] & ~clr[k]) | i_pwm_ready[k];
         ovr_d[k]    = (ovr_q[k] & ~i_clr_overrun) | (i_pwm_ready[k] & pend_q[k] & ~clr[k]);
         shadow_d[k] = i_pwm_ready[k] ? i_pwm_value[16*k +: 16] : shadow_q[k];
`ifdef PWM_SCHED_LASTGOOD_EN
         regs_d[k]   = cap_ok ? i_pwm_value[16*k +: 16] : regs_q[k];
`else
         regs_d[k]   = i_pwm_ready[k] ? i_pwm_value[16*k +: 16] : regs_q[k];
`endif
         age_d[k]    = cap_ok ? '0 : (ms_tick && age_q[k] != '1) ? age_q[k] + 10'd1 : age_q[k];
         valid_d[k]  = cap_ok ? 1'b1 :
                       ((i_pwm_ready[k] && cap_st[1]) || age_d[k] >= 10'(TIMEOUT_MS)) ? 1'b0 : valid_q[k];
      end
      rd_d = ({1'b0, i_rd_ch} < 5'(NUM_CH)) ? regs_q[i_rd_ch[SW-1:0]] : '0;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= S_IDLE;
         pend_q    <= '0;
         valid_q   <= '0;
         ovr_q     <= '0;
         rr_q      <= '0;
         upd_ch_q  <= '0;
         upd_val_q <= '0;
         upd_st_q  <= ST_OK;
         rd_q      <= '0;
         presc_q   <= '0;
         ms_cnt_q  <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            shadow_q[k] <= '0;
            regs_q[k]   <= '0;
            age_q[k]    <= '0;
         end
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         valid_q   <= valid_d;
         ovr_q     <= ovr_d;
         rr_q      <= rr_d;
         upd_ch_q  <= upd_ch_d;
         upd_val_q <= upd_val_d;
         upd_st_q  <= upd_st_d;
         rd_q      <= rd_d;
         presc_q   <= presc_d;
         ms_cnt_q  <= ms_cnt_d;
         for (int k = 0; k < NUM_CH; k++) begin
            shadow_q[k] <= shadow_d[k];
            regs_q[k]   <= regs_d[k];
            age_q[k]    <= age_d[k];
         end
      end
   end

   assign o_upd_valid  = state_q == S_PRESENT;
   assign o_upd_ch     = upd_ch_q;
   assign o_upd_value  = upd_val_q;
   assign o_upd_status = upd_st_q;
   assign o_rd_value   = rd_q;
   assign o_ch_valid   = valid_q;
   assign o_failsafe   = ~&valid_q;
   assign o_overrun    = ovr_q;
endmodule

// File: tb/tb_pwm_channel_scheduler.sv
// tb_pwm_channel_scheduler: directed checks of capture, round-robin streaming, status, staleness and reset
module tb_pwm_channel_scheduler;
   localparam int N   = 8;
   localparam int TMO = 4;
`ifdef PWM_SCHED_LASTGOOD_EN
   localparam logic [15:0] LOST_REG = 16'd1200;
`else
   localparam logic [15:0] LOST_REG = 16'hCE20;
`endif

   logic           i_clk = 1'b0;
   logic           i_reset = 1'b1;
   logic [N-1:0]   i_pwm_ready = '0;
   logic [16*N-1:0] i_pwm_value = '0;
   logic           i_upd_ready = 1'b0;
   logic           i_clr_overrun = 1'b0;
   logic [3:0]     i_rd_ch = '0;
   logic           o_upd_valid, o_failsafe;
   logic [3:0]     o_upd_ch;
   logic [15:0]    o_upd_value, o_rd_value;
   logic [1:0]     o_upd_status;
   logic [N-1:0]   o_ch_valid, o_overrun;
   int             n_chk = 0;
   int             n_err = 0;

   pwm_channel_scheduler #(.NUM_CH(N), .clockFreq(1000000), .TIMEOUT_MS(TMO)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_pwm_ready  (i_pwm_ready),
      .i_pwm_value  (i_pwm_value),
      .o_upd_valid  (o_upd_valid),
      .i_upd_ready  (i_upd_ready),
      .o_upd_ch     (o_upd_ch),
      .o_upd_value  (o_upd_value),
      .o_upd_status (o_upd_status),
      .i_rd_ch      (i_rd_ch),
      .o_rd_value   (o_rd_value),
      .o_ch_valid   (o_ch_valid),
      .o_failsafe   (o_failsafe),
      .o_overrun    (o_overrun),
      .i_clr_overrun(i_clr_overrun)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic setv(input int ch, input logic [15:0] v);
      i_pwm_value[16*ch +: 16] = v;
   endtask

   task automatic pulse(input logic [N-1:0] m);
      i_pwm_ready = m;
      tick();
      i_pwm_ready = '0;
   endtask

   task automatic take(input string tag, input int ch, input logic [15:0] v, input int st);
      int n = 0;
      while (!o_upd_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 32'(o_upd_valid), 32'd1);
      chk({tag, "_ch"}, 32'(o_upd_ch), 32'(ch));
      chk({tag, "_value"}, 32'(o_upd_value), 32'(v));
      chk({tag, "_status"}, 32'(o_upd_status), 32'(st));
      tick();
      chk({tag, "_hold"}, 32'({o_upd_valid, o_upd_ch, o_upd_value}), 32'({1'b1, 4'(ch), v}));
      i_upd_ready = 1'b1;
      tick();
      i_upd_ready = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
      $fatal(1);
   end

   initial begin
      repeat (2) tick();
      chk("rst_valid", 32'(o_upd_valid), 32'd0);
      chk("rst_chv", 32'(o_ch_valid), 32'd0);
      chk("rst_failsafe", 32'(o_failsafe), 32'd1);
      chk("rst_overrun", 32'(o_overrun), 32'd0);
      i_reset = 1'b0;
      tick();
      chk("rst_rd", 32'(o_rd_value), 32'd0);

      setv(2, 16'd1500);
      i_upd_ready = 1'b1;
      pulse(8'h04);
      chk("lat_not_yet", 32'(o_upd_valid), 32'd0);
      chk("lat_chv2", 32'(o_ch_valid[2]), 32'd1);
      tick();
      chk("lat_valid", 32'(o_upd_valid), 32'd1);
      chk("lat_upd", 32'({o_upd_ch, o_upd_value, o_upd_status}), 32'({4'd2, 16'd1500, 2'd0}));
      tick();
      chk("lat_done", 32'(o_upd_valid), 32'd0);
      i_upd_ready = 1'b0;
      i_rd_ch = 4'd2;
      tick();
      chk("rd_ch2", 32'(o_rd_value), 32'd1500);
      i_rd_ch = 4'd8;
      tick();
      chk("rd_oob8", 32'(o_rd_value), 32'd0);
      i_rd_ch = 4'd15;
      tick();
      chk("rd_oob15", 32'(o_rd_value), 32'd0);

      setv(3, 16'd1200);
      pulse(8'h08);
      take("rr_pre", 3, 16'd1200, 0);
      setv(0, 16'd900);
      setv(3, 16'd2000);
      setv(5, 16'd2600);
      pulse(8'b0010_1001);
      take("rr_a", 5, 16'd2600, 0);
      take("rr_b", 0, 16'd900, 0);
      take("rr_c", 3, 16'd2000, 0);

      setv(1, 16'd1200);
      pulse(8'h02);
      chk("lost_pre_chv", 32'(o_ch_valid[1]), 32'd1);
      take("lost_pre", 1, 16'd1200, 0);
      i_rd_ch = 4'd1;
      tick();
      chk("lost_pre_rd", 32'(o_rd_value), 32'd1200);
      setv(1, 16'hCE20);
      pulse(8'h02);
      chk("lost_chv", 32'(o_ch_valid[1]), 32'd0);
      take("lost", 1, 16'hCE20, 2);
      chk("lost_rd", 32'(o_rd_value), 32'(LOST_REG));

      setv(7, 16'd1000);
      pulse(8'h80);
      chk("r_ok_chv", 32'(o_ch_valid[7]), 32'd1);
      take("r_ok", 7, 16'd1000, 0);
      setv(7, 16'd799);
      pulse(8'h80);
      chk("r_799_chv", 32'(o_ch_valid[7]), 32'd1);
      take("r_799", 7, 16'd799, 1);
      setv(7, 16'd2601);
      pulse(8'h80);
      take("r_2601", 7, 16'd2601, 1);
      setv(7, 16'd800);
      pulse(8'h80);
      take("r_800", 7, 16'd800, 0);
      setv(7, 16'h8123);
      pulse(8'h80);
      chk("high_chv", 32'(o_ch_valid[7]), 32'd0);
      take("high", 7, 16'h8123, 3);

      setv(0, 16'd1000);
      pulse(8'h01);
      setv(6, 16'd1100);
      pulse(8'h40);
      setv(6, 16'd1900);
      pulse(8'h40);
      chk("ovr_flag", 32'(o_overrun), 32'h40);
      take("ovr_busy", 0, 16'd1000, 0);
      take("ovr", 6, 16'd1900, 0);
      repeat (3) tick();
      chk("ovr_single", 32'(o_upd_valid), 32'd0);
      i_clr_overrun = 1'b1;
      tick();
      i_clr_overrun = 1'b0;
      chk("ovr_clr", 32'(o_overrun), 32'd0);

      setv(0, 16'd1000);
      pulse(8'h01);
      setv(6, 16'd1100);
      pulse(8'h40);
      i_clr_overrun = 1'b1;
      setv(6, 16'd1200);
      pulse(8'h40);
      i_clr_overrun = 1'b0;
      chk("ovr_clr_coinc", 32'(o_overrun), 32'h40);
      take("coinc_busy", 0, 16'd1000, 0);
      take("coinc", 6, 16'd1200, 0);
      i_clr_overrun = 1'b1;
      tick();
      i_clr_overrun = 1'b0;

      setv(6, 16'd1300);
      pulse(8'h40);
      setv(6, 16'd1400);
      pulse(8'h40);
      take("simul_old", 6, 16'd1300, 0);
      take("simul_new", 6, 16'd1400, 0);

      setv(4, 16'd1000);
      pulse(8'h10);
      chk("tmo_set", 32'(o_ch_valid[4]), 32'd1);
      take("tmo_upd", 4, 16'd1000, 0);
      repeat ((TMO - 1) * 1000 - 20) tick();
      chk("tmo_before", 32'(o_ch_valid[4]), 32'd1);
      repeat (1040) tick();
      chk("tmo_after", 32'(o_ch_valid[4]), 32'd0);
      chk("tmo_all", 32'(o_ch_valid), 32'd0);
      chk("tmo_failsafe", 32'(o_failsafe), 32'd1);

      for (int k = 0; k < N; k++) setv(k, 16'(1000 + k));
      pulse('1);
      chk("all_chv", 32'(o_ch_valid), 32'hFF);
      chk("all_failsafe", 32'(o_failsafe), 32'd0);
      tick();
      chk("arst_present", 32'(o_upd_valid), 32'd1);
      #3 i_reset = 1'b1;
      #1;
      chk("arst_valid", 32'(o_upd_valid), 32'd0);
      chk("arst_chv", 32'(o_ch_valid), 32'd0);
      chk("arst_failsafe", 32'(o_failsafe), 32'd1);
      tick();
      i_reset = 1'b0;
      repeat (3) tick();
      chk("arst_discard", 32'(o_upd_valid), 32'd0);
      i_rd_ch = 4'd3;
      tick();
      chk("arst_rd", 32'(o_rd_value), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
